// File: rtl/player_motion_ctrl_if.sv
// Player motion bus: frame/key/collision inputs into the controller and the
// pose/target outputs it produces for the animation, scroll and collision stages.
interface player_motion_ctrl_if;
  logic       frame_start;
  logic [7:0] keycode;
  logic       blocked_in;
  logic [5:0] target_tx;
  logic [5:0] target_ty;
  logic       Character_Moving;
  logic [1:0] Direction;
  logic [9:0] Pos_X;
  logic [9:0] Pos_Y;
  logic       Step_Done;

  modport master (
    output frame_start, keycode, blocked_in,
    input  target_tx, target_ty, Character_Moving, Direction, Pos_X, Pos_Y, Step_Done
  );

  modport slave (
    input  frame_start, keycode, blocked_in,
    output target_tx, target_ty, Character_Moving, Direction, Pos_X, Pos_Y, Step_Done
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// Tile-based overworld movement: keycode -> facing, collision-checked tile steps
// advanced one STEP_PX per frame, with a short bump animation against walls.
module player_motion_ctrl #(
  parameter int TILE_PX     = 16,
  parameter int STEP_PX     = 1,
  parameter int MAP_W_TILES = 64,
  parameter int MAP_H_TILES = 64,
  parameter int START_TX    = 10,
  parameter int START_TY    = 12,
  parameter int BUMP_FRAMES = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  player_motion_ctrl_if.slave   bus
);
  localparam int TSH = $clog2(TILE_PX);
  localparam int CW  = $clog2(TILE_PX + 1);
  localparam int BW  = $clog2(BUMP_FRAMES + 1);

  localparam logic [9:0]    START_X  = 10'(START_TX * TILE_PX);
  localparam logic [9:0]    START_Y  = 10'(START_TY * TILE_PX);
  localparam logic [5:0]    START_C  = 6'(START_TX);
  localparam logic [5:0]    START_R  = 6'(START_TY);
  localparam logic [5:0]    MAX_TX   = 6'(MAP_W_TILES - 1);
  localparam logic [5:0]    MAX_TY   = 6'(MAP_H_TILES - 1);
  localparam logic [9:0]    STEP_POS = 10'(STEP_PX);
  localparam logic [CW-1:0] STEP_CNT = CW'(STEP_PX);
  localparam logic [CW-1:0] TILE_CNT = CW'(TILE_PX);
  localparam logic [BW-1:0] BUMP_CNT = BW'(BUMP_FRAMES);

  typedef enum logic [1:0] {IDLE, CHECK, WALK, BUMP} state_t;

  state_t        state, state_nx;
  logic [1:0]    dir, dir_nx;
  logic [9:0]    pos_x, pos_x_nx, pos_y, pos_y_nx;
  logic [5:0]    tgt_x, tgt_x_nx, tgt_y, tgt_y_nx;
  logic [CW-1:0] pix_cnt, pix_cnt_nx, pix_inc;
  logic [BW-1:0] bump_cnt, bump_cnt_nx;
  logic          step_done, step_done_nx;
  logic          key_vld;
  logic [1:0]    key_dir;
  logic [5:0]    tile_x, tile_y;
  logic          out_of_map;

  // Adjacent tile in direction d; edge wrap is harmless because CHECK bounds it.
  function automatic logic [11:0] neighbour(input logic [5:0] tx, input logic [5:0] ty,
                                            input logic [1:0] d);
    logic [5:0] nx, ny;
    nx = tx;
    ny = ty;
    case (d)
      2'd0:    ny = ty - 6'd1;
      2'd1:    nx = tx + 6'd1;
      2'd2:    ny = ty + 6'd1;
      default: nx = tx - 6'd1;
    endcase
    return {nx, ny};
  endfunction

  always_comb begin
    key_vld = 1'b1;
    key_dir = 2'd0;
    case (bus.keycode)
      8'h1A:   key_dir = 2'd0;
      8'h07:   key_dir = 2'd1;
      8'h16:   key_dir = 2'd2;
      8'h04:   key_dir = 2'd3;
      default: key_vld = 1'b0;
    endcase
  end

  // Position is tile-aligned whenever this is consulted (IDLE/CHECK).
  assign tile_x  = pos_x[TSH +: 6];
  assign tile_y  = pos_y[TSH +: 6];
  assign pix_inc = pix_cnt + STEP_CNT;

  always_comb begin
    case (dir)
      2'd0:    out_of_map = (tile_y == 6'd0);
      2'd1:    out_of_map = (tile_x == MAX_TX);
      2'd2:    out_of_map = (tile_y == MAX_TY);
      default: out_of_map = (tile_x == 6'd0);
    endcase
  end

  always_comb begin
    state_nx     = state;
    dir_nx       = dir;
    pos_x_nx     = pos_x;
    pos_y_nx     = pos_y;
    tgt_x_nx     = tgt_x;
    tgt_y_nx     = tgt_y;
    pix_cnt_nx   = pix_cnt;
    bump_cnt_nx  = bump_cnt;
    step_done_nx = 1'b0;
    case (state)
      IDLE: begin
        if (bus.frame_start && key_vld) begin
          dir_nx               = key_dir;
          {tgt_x_nx, tgt_y_nx} = neighbour(tile_x, tile_y, key_dir);
          state_nx             = CHECK;
        end
      end
      CHECK: begin
        if (out_of_map || bus.blocked_in) begin
          state_nx    = BUMP;
          bump_cnt_nx = '0;
        end else begin
          state_nx   = WALK;
          pix_cnt_nx = '0;
        end
      end
      WALK: begin
        if (bus.frame_start) begin
          pix_cnt_nx = pix_inc;
          if (pix_inc == TILE_CNT) begin
            // Land exactly on the target tile; a held key chains the next step.
            pos_x_nx     = {4'b0, tgt_x} << TSH;
            pos_y_nx     = {4'b0, tgt_y} << TSH;
            step_done_nx = 1'b1;
            if (key_vld) begin
              dir_nx               = key_dir;
              {tgt_x_nx, tgt_y_nx} = neighbour(tgt_x, tgt_y, key_dir);
              state_nx             = CHECK;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            case (dir)
              2'd0:    pos_y_nx = pos_y - STEP_POS;
              2'd1:    pos_x_nx = pos_x + STEP_POS;
              2'd2:    pos_y_nx = pos_y + STEP_POS;
              default: pos_x_nx = pos_x - STEP_POS;
            endcase
          end
        end
      end
      BUMP: begin
        if (bus.frame_start) begin
          bump_cnt_nx = bump_cnt + BW'(1);
          if (bump_cnt_nx == BUMP_CNT) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      dir       <= 2'd0;
      pos_x     <= START_X;
      pos_y     <= START_Y;
      tgt_x     <= START_C;
      tgt_y     <= START_R;
      pix_cnt   <= '0;
      bump_cnt  <= '0;
      step_done <= 1'b0;
    end else begin
      state     <= state_nx;
      dir       <= dir_nx;
      pos_x     <= pos_x_nx;
      pos_y     <= pos_y_nx;
      tgt_x     <= tgt_x_nx;
      tgt_y     <= tgt_y_nx;
      pix_cnt   <= pix_cnt_nx;
      bump_cnt  <= bump_cnt_nx;
      step_done <= step_done_nx;
    end
  end

  assign bus.target_tx        = tgt_x;
  assign bus.target_ty        = tgt_y;
  assign bus.Character_Moving = (state != IDLE);
  assign bus.Direction        = dir;
  assign bus.Pos_X            = pos_x;
  assign bus.Pos_Y            = pos_y;
  assign bus.Step_Done        = step_done;
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: per-frame pose scoreboard plus a
// Step_Done monitor that pops the expected landing position of each step.
module tb_player_motion_ctrl;
  logic Clk = 1'b0;
  logic Reset;
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;
  int   mov_low = 0;
  logic mov_mon_en = 1'b0;

  logic [22:0] exp_q[$];
  logic [19:0] sd_q[$];

  player_motion_ctrl_if bus ();

  player_motion_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    @(negedge Clk) bus.frame_start = 1'b1;
    @(negedge Clk) bus.frame_start = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic frame_exp(input string tag, input logic [9:0] x, input logic [9:0] y,
                           input logic [1:0] d, input logic m);
    logic [22:0] e;
    exp_q.push_back({x, y, d, m});
    frame();
    e = exp_q.pop_front();
    chk(tag, {9'b0, bus.Pos_X, bus.Pos_Y, bus.Direction, bus.Character_Moving}, {9'b0, e});
  endtask

  always @(negedge Clk) begin
    if (Reset !== 1'b1 && bus.Step_Done === 1'b1) begin
      if (sd_q.size() == 0) chk("step_done_unexpected", 32'd1, 32'd0);
      else chk("step_done_pos", {12'b0, bus.Pos_X, bus.Pos_Y}, {12'b0, sd_q.pop_front()});
    end
    if (mov_mon_en && bus.Character_Moving !== 1'b1) mov_low++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset           = 1'b1;
    bus.frame_start = 1'b0;
    bus.keycode     = 8'h00;
    bus.blocked_in  = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    // Reset state and idle frames without a key
    chk("rst_pos", {12'b0, bus.Pos_X, bus.Pos_Y}, {12'b0, 10'd160, 10'd192});
    chk("rst_dir_mov", {29'b0, bus.Direction, bus.Character_Moving}, 32'd0);
    chk("rst_target", {20'b0, bus.target_tx, bus.target_ty}, {20'b0, 6'd10, 6'd12});
    chk("rst_step_done", {31'b0, bus.Step_Done}, 32'd0);
    for (int f = 0; f < 5; f++) frame_exp("idle_frame", 10'd160, 10'd192, 2'd0, 1'b0);

    // Single right step, key tapped for one frame
    sd_q.push_back({10'd176, 10'd192});
    bus.keycode = 8'h07;
    frame_exp("right_start", 10'd160, 10'd192, 2'd1, 1'b1);
    bus.keycode = 8'h00;
    chk("right_target", {20'b0, bus.target_tx, bus.target_ty}, {20'b0, 6'd11, 6'd12});
    for (int i = 1; i <= 16; i++)
      frame_exp("right_walk", 10'(160 + i), 10'd192, 2'd1, (i < 16));

    // Two chained down steps, no idle frame between them
    sd_q.push_back({10'd176, 10'd208});
    sd_q.push_back({10'd176, 10'd224});
    bus.keycode = 8'h16;
    frame_exp("down_start", 10'd176, 10'd192, 2'd2, 1'b1);
    mov_mon_en = 1'b1;
    for (int f = 2; f <= 33; f++) begin
      if (f == 33) begin
        mov_mon_en  = 1'b0;
        bus.keycode = 8'h00;
      end
      frame_exp("down_walk", 10'd176, 10'(192 + f - 1), 2'd2, (f < 33));
    end
    chk("down_moving_gap", mov_low, 32'd0);

    // Blocked move up: face the wall and bump
    bus.blocked_in = 1'b1;
    bus.keycode    = 8'h1A;
    frame_exp("bump_start", 10'd176, 10'd224, 2'd0, 1'b1);
    bus.keycode = 8'h00;
    chk("bump_target", {20'b0, bus.target_tx, bus.target_ty}, {20'b0, 6'd11, 6'd13});
    for (int f = 2; f <= 9; f++)
      frame_exp("bump_frame", 10'd176, 10'd224, 2'd0, (f < 9));
    bus.blocked_in = 1'b0;

    // Walk left to column 0, then bump against the map edge
    for (int k = 0; k <= 10; k++) sd_q.push_back({10'(160 - 16 * k), 10'd224});
    bus.keycode = 8'h04;
    for (int f = 1; f <= 177; f++) begin
      frame_exp("left_walk", (f == 1) ? 10'd176 : 10'(176 - (f - 1)), 10'd224, 2'd3, 1'b1);
      if (f == 177) bus.keycode = 8'h00;
    end
    for (int b = 1; b <= 8; b++)
      frame_exp("left_edge_bump", 10'd0, 10'd224, 2'd3, (b < 8));

    // Walk right to column 63, then bump against the far edge
    for (int k = 1; k <= 63; k++) sd_q.push_back({10'(16 * k), 10'd224});
    bus.keycode = 8'h07;
    for (int f = 1; f <= 1009; f++) begin
      frame_exp("right_long", (f == 1) ? 10'd0 : 10'(f - 1), 10'd224, 2'd1, 1'b1);
      if (f == 1009) bus.keycode = 8'h00;
    end
    for (int b = 1; b <= 8; b++)
      frame_exp("right_edge_bump", 10'd1008, 10'd224, 2'd1, (b < 8));

    // Reset in the middle of a step discards the partial move
    bus.keycode = 8'h04;
    frame_exp("abort_start", 10'd1008, 10'd224, 2'd3, 1'b1);
    bus.keycode = 8'h00;
    for (int f = 1; f <= 6; f++)
      frame_exp("abort_walk", 10'(1008 - f), 10'd224, 2'd3, 1'b1);
    Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
    chk("abort_pos", {12'b0, bus.Pos_X, bus.Pos_Y}, {12'b0, 10'd160, 10'd192});
    chk("abort_dir_mov", {29'b0, bus.Direction, bus.Character_Moving}, 32'd0);
    for (int f = 0; f < 3; f++) frame_exp("abort_idle", 10'd160, 10'd192, 2'd0, 1'b0);
    chk("step_done_all_seen", sd_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
